// File: rtl/sprite_pixel_fetch_if.sv
// Sprite pixel-fetch bus: scan position, sprite placement/animation controls,
// the synchronous sprite ROM port and the per-pixel outputs to the palette
// stage. Clock and reset stay plain ports on the modules.
//   master : scan/control source and sprite ROM (drives inputs, rom_data)
//   slave  : sprite_pixel_fetch (drives rom_addr, palette_index, sprite_on, frame)
interface sprite_pixel_fetch_if #(
    parameter int ADDR_W = 13,
    parameter int FRAMES = 4
);
    localparam int FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        spr_x;
    logic [9:0]        spr_y;
    logic              flip;
    logic              anim_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        palette_index;
    logic              sprite_on;
    logic [FRM_W-1:0]  frame;

    modport master (
        output frame_start, DrawX, DrawY, spr_x, spr_y, flip, anim_en, rom_data,
        input  rom_addr, palette_index, sprite_on, frame
    );

    modport slave (
        input  frame_start, DrawX, DrawY, spr_x, spr_y, flip, anim_en, rom_data,
        output rom_addr, palette_index, sprite_on, frame
    );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: maps the scan position to a sprite ROM address, reads the
// 4-bit palette index back and flags opaque in-sprite pixels, three cycles after
// DrawX/DrawY are presented. Sprite position, flip and animation frame change
// only on frame_start so a sprite never tears mid-frame.
// Ports:
//   Clk   - pixel clock
//   Reset - synchronous active-high reset, clears every register
//   bus   - sprite_pixel_fetch_if.slave (scan inputs, controls, ROM port, outputs)
module sprite_pixel_fetch #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 48,
    parameter int FRAMES     = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 13,
    parameter int TRANSP_IDX = 0
) (
    input logic                  Clk,
    input logic                  Reset,
    sprite_pixel_fetch_if.slave  bus
);
    localparam int FRM_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    // Frame-synchronous latched controls
    logic [9:0]        px_q, py_q;
    logic              pf_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FRM_W-1:0]  frame_q, frame_d;

    // Pipeline state
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              hit_d, hit_p1_q, hit_p2_q;
    logic [3:0]        pal_q;
    logic              on_q;

    // Stage 1 combinational: offsets into the sprite box
    logic signed [10:0] rx, ry;
    logic [ADDR_W-1:0]  rx_u, ry_u, col;

    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        if (bus.frame_start) begin
            if (!bus.anim_en) begin
                hold_d  = '0;
                frame_d = '0;
            end else if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d  = '0;
                frame_d = (frame_q == FRM_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        // Zero-extended 11-bit differences; bit 10 set means the pixel is left of / above the sprite.
        rx    = $signed({1'b0, bus.DrawX}) - $signed({1'b0, px_q});
        ry    = $signed({1'b0, bus.DrawY}) - $signed({1'b0, py_q});
        rx_u  = ADDR_W'(rx[9:0]);
        ry_u  = ADDR_W'(ry[9:0]);
        hit_d = !rx[10] && ({1'b0, rx[9:0]} < 11'(SPR_W)) &&
                !ry[10] && ({1'b0, ry[9:0]} < 11'(SPR_H));
        col   = pf_q ? (ADDR_W'(SPR_W - 1) - rx_u) : rx_u;
        addr_d = '0;
        if (hit_d) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) + ry_u * ADDR_W'(SPR_W) + col;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            px_q     <= '0;
            py_q     <= '0;
            pf_q     <= 1'b0;
            hold_q   <= '0;
            frame_q  <= '0;
            addr_q   <= '0;
            hit_p1_q <= 1'b0;
            hit_p2_q <= 1'b0;
            pal_q    <= '0;
            on_q     <= 1'b0;
        end else begin
            // Latch: new placement applies to pixels sampled after the pulse cycle
            if (bus.frame_start) begin
                px_q <= bus.spr_x;
                py_q <= bus.spr_y;
                pf_q <= bus.flip;
            end
            hold_q  <= hold_d;
            frame_q <= frame_d;
            // Stage 1 -> ROM address register
            addr_q   <= addr_d;
            hit_p1_q <= hit_d;
            // Stage 2 -> hit flag follows the ROM access
            hit_p2_q <= hit_p1_q;
            // Stage 3 -> output register
            pal_q <= hit_p2_q ? bus.rom_data : 4'(TRANSP_IDX);
            on_q  <= hit_p2_q && (bus.rom_data != 4'(TRANSP_IDX));
        end
    end

    assign bus.rom_addr      = addr_q;
    assign bus.palette_index = pal_q;
    assign bus.sprite_on     = on_q;
    assign bus.frame         = frame_q;
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
module tb_sprite_pixel_fetch;
    localparam int SPR_W      = 32;
    localparam int SPR_H      = 48;
    localparam int FRAMES     = 4;
    localparam int FRAME_HOLD = 6;
    localparam int ADDR_W     = 13;
    localparam int TRANSP     = 0;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sprite_pixel_fetch_if #(.ADDR_W(ADDR_W), .FRAMES(FRAMES)) bus ();

    sprite_pixel_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .FRAME_HOLD(FRAME_HOLD), .ADDR_W(ADDR_W), .TRANSP_IDX(TRANSP)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // Synchronous ROM whose content is the low nibble of the address
    always @(posedge Clk) bus.rom_data <= bus.rom_addr[3:0];

    int checks   = 0;
    int failures = 0;

    // Stimulus for the next cycle
    logic       rst_v;
    logic       fs, fl, ae;
    logic [9:0] dx, dy, sx, sy;

    // Reference model: latched placement and count of consecutive enabled pulses
    int mpx, mpy, mpf, mn;
    int qpal[$];
    int qon[$];
    int last_addr;

    function automatic int model_frame();
        return (mn / FRAME_HOLD) % FRAMES;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int rx, ry, col, ea;
        bit hit;
        @(negedge Clk);
        Reset           = rst_v;
        bus.frame_start = fs;
        bus.DrawX       = dx;
        bus.DrawY       = dy;
        bus.spr_x       = sx;
        bus.spr_y       = sy;
        bus.flip        = fl;
        bus.anim_en     = ae;
        rx  = int'(dx) - mpx;
        ry  = int'(dy) - mpy;
        hit = (rx >= 0) && (rx < SPR_W) && (ry >= 0) && (ry < SPR_H);
        col = (mpf != 0) ? (SPR_W - 1 - rx) : rx;
        ea  = hit ? (model_frame() * SPR_W * SPR_H + ry * SPR_W + col) : 0;
        @(posedge Clk);
        #1;
        if (rst_v) begin
            check("rst_addr",  32'(bus.rom_addr), 0);
            check("rst_pal",   32'(bus.palette_index), 0);
            check("rst_on",    32'(bus.sprite_on), 0);
            check("rst_frame", 32'(bus.frame), 0);
            mpx = 0; mpy = 0; mpf = 0; mn = 0;
            qpal.delete(); qon.delete();
            repeat (2) begin
                qpal.push_back(0);
                qon.push_back(0);
            end
            last_addr = 0;
        end else begin
            check("addr", 32'(bus.rom_addr), 32'(ea));
            qpal.push_back(hit ? (ea % 16) : TRANSP);
            qon.push_back((hit && (ea % 16) != TRANSP) ? 1 : 0);
            if (qpal.size() >= 3) begin
                check("pal", 32'(bus.palette_index), 32'(qpal.pop_front()));
                check("on",  32'(bus.sprite_on),     32'(qon.pop_front()));
            end
            if (fs) begin
                mpx = int'(sx); mpy = int'(sy); mpf = int'(fl);
                mn  = ae ? mn + 1 : 0;
            end
            check("frame", 32'(bus.frame), 32'(model_frame()));
            last_addr = ea;
        end
    endtask

    task automatic pulse();
        fs = 1'b1;
        cyc();
        fs = 1'b0;
    endtask

    task automatic flush();
        dx = 10'd0; dy = 10'd0;
        repeat (3) cyc();
    endtask

    initial begin
        mpx = 0; mpy = 0; mpf = 0; mn = 0; last_addr = 0;
        fs = 0; fl = 0; ae = 0; dx = 0; dy = 0; sx = 0; sy = 0;

        // Reset with random inputs
        rst_v = 1'b1;
        repeat (4) begin
            fs = 1'($urandom); fl = 1'($urandom); ae = 1'($urandom);
            dx = 10'($urandom); dy = 10'($urandom);
            sx = 10'($urandom); sy = 10'($urandom);
            cyc();
        end
        rst_v = 1'b0;
        fs = 0; ae = 0; fl = 0;
        dx = 10'd0; dy = 10'd0; sx = 10'd0; sy = 10'd0;
        cyc();
        check("post_rst_on", 32'(bus.sprite_on), 0);

        // Unflipped row sweep
        sx = 10'd100; sy = 10'd50; fl = 1'b0;
        pulse();
        dy = 10'd50;
        for (int x = 99; x <= 132; x++) begin
            dx = 10'(x);
            cyc();
            if (x == 100) check("noflip_x100", 32'(bus.rom_addr), 0);
            if (x == 131) check("noflip_x131", 32'(bus.rom_addr), 31);
            if (x == 132) check("noflip_x132", 32'(bus.rom_addr), 0);
        end
        flush();

        // Mirrored row sweep
        fl = 1'b1;
        pulse();
        dy = 10'd50;
        for (int x = 99; x <= 132; x++) begin
            dx = 10'(x);
            cyc();
            if (x == 100) check("flip_x100", 32'(bus.rom_addr), 31);
            if (x == 131) check("flip_x131", 32'(bus.rom_addr), 0);
        end
        flush();

        // Animation sequencing
        fl = 1'b0; ae = 1'b1;
        for (int p = 1; p <= 12; p++) pulse();
        check("frame_at_12", 32'(bus.frame), 2);
        dx = 10'd100; dy = 10'd50;
        cyc();
        check("frame2_origin", 32'(bus.rom_addr), 3072);
        for (int p = 13; p <= 24; p++) begin
            pulse();
            if (p == 18) check("frame_at_18", 32'(bus.frame), 3);
        end
        check("frame_at_24", 32'(bus.frame), 0);
        repeat (6) pulse();
        check("frame_at_30", 32'(bus.frame), 1);
        ae = 1'b0;
        pulse();
        check("frame_anim_off", 32'(bus.frame), 0);
        flush();

        // Mid-frame position change takes effect only after the next pulse
        sx = 10'd200;
        dx = 10'd105; dy = 10'd50;
        cyc();
        check("midframe_old", 32'(bus.rom_addr), 5);
        dx = 10'd205;
        pulse();
        check("pulse_cycle_old", 32'(bus.rom_addr), 0);
        cyc();
        check("after_pulse_new", 32'(bus.rom_addr), 5);
        dx = 10'd105;
        cyc();
        check("old_pos_miss", 32'(bus.rom_addr), 0);
        flush();

        // Negative offsets miss, no screen-edge wrap
        sx = 10'd1000; sy = 10'd0;
        pulse();
        dx = 10'd5; dy = 10'd0;
        cyc();
        check("neg_rx_miss", 32'(bus.rom_addr), 0);
        sx = 10'd0;
        pulse();
        dx = 10'd1023;
        cyc();
        check("x1023_miss", 32'(bus.rom_addr), 0);
        dx = 10'd31; dy = 10'd47;
        cyc();
        check("corner_hit", 32'(bus.rom_addr), 1535);
        flush();

        // Randomized traffic around a moving sprite
        for (int i = 0; i < 600; i++) begin
            rst_v = ($urandom_range(0, 199) == 0);
            fs = ($urandom_range(0, 15) == 0);
            if (fs) begin
                sx = 10'($urandom);
                sy = 10'($urandom);
                fl = 1'($urandom);
                ae = ($urandom_range(0, 7) != 0);
            end
            dx = 10'(int'(bus.spr_x) + int'($urandom_range(0, SPR_W + 8)) - 4);
            dy = 10'(int'(bus.spr_y) + int'($urandom_range(0, SPR_H + 8)) - 4);
            cyc();
        end
        rst_v = 1'b0; fs = 1'b0;
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
